// File: rtl/mem_access.sv
// mem_access: memory stage of the pipeline. Resolves branch redirect, runs
// loads/stores over a req/gnt/rvalid handshake with one access outstanding,
// stalls upstream while busy, and extracts/extends load data for write-back.
// Optional watchdog on REQ/WAIT enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic               mem_read_in,
    input  logic               mem_write_in,
    input  logic               branch_in,
    input  logic [2:0]         funct3_in,
    input  logic               zero_in,
    input  logic [WIDTH-1:0]   alu_res_in,
    input  logic [WIDTH-1:0]   rs2_in,
    input  logic [WIDTH-1:0]   pc_branch_in,
    output logic               pc_src_out,
    output logic [WIDTH-1:0]   pc_branch_out,
    output logic               stall_out,
    output logic               dmem_req_out,
    output logic               dmem_we_out,
    output logic [WIDTH-1:0]   dmem_addr_out,
    output logic [WIDTH/8-1:0] dmem_be_out,
    output logic [WIDTH-1:0]   dmem_wdata_out,
    input  logic               dmem_gnt_in,
    input  logic               dmem_rvalid_in,
    input  logic [WIDTH-1:0]   dmem_rdata_in,
    output logic [WIDTH-1:0]   rd_data_out,
    output logic               rd_valid_out,
    output logic               access_err_out,
    output logic               bus_err_out
);

    localparam int unsigned BE_W = WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Elaboration guard: datapath slicing assumes a 32-bit word, watchdog needs a nonzero limit
    if (WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("mem_access: WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             abort_c;
    logic             timeout_c;
    logic             load_done_c;

    logic             is_mem_c;
    logic             f3_legal_c;
    logic             aligned_c;
    logic             legal_mem_c;
    logic [BE_W-1:0]  be_c;
    logic [WIDTH-1:0] wdata_c;

    logic [1:0]       addr_lo_q;
    logic [2:0]       f3_q;
    logic             is_load_q;

    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [WIDTH-1:0] load_data_c;

    // Branch redirect is resolved combinationally from the EX flags
    assign pc_src_out    = valid_in & branch_in & zero_in;
    assign pc_branch_out = pc_branch_in;

    // Hold upstream while an access is in flight or one is being accepted
    assign stall_out = (state != S_IDLE) | (valid_in & legal_mem_c);

    // Decode access legality and build store byte lanes from the incoming op
    always_comb begin
        is_mem_c   = mem_read_in | mem_write_in;
        f3_legal_c = 1'b0;
        aligned_c  = 1'b1;
        be_c       = '0;
        wdata_c    = rs2_in;
        case (funct3_in)
            F3_B, F3_BU: begin
                f3_legal_c = 1'b1;
                be_c       = BE_W'(4'b0001) << alu_res_in[1:0];
                wdata_c    = {4{rs2_in[7:0]}};
            end
            F3_H, F3_HU: begin
                f3_legal_c = 1'b1;
                aligned_c  = ~alu_res_in[0];
                be_c       = BE_W'(4'b0011) << alu_res_in[1:0];
                wdata_c    = {2{rs2_in[15:0]}};
            end
            F3_W: begin
                f3_legal_c = 1'b1;
                aligned_c  = (alu_res_in[1:0] == 2'b00);
                be_c       = '1;
            end
            default: ;
        endcase
        legal_mem_c = is_mem_c & f3_legal_c & aligned_c;
    end

    // Pick the addressed byte/half of the returned word and extend it
    always_comb begin
        case (addr_lo_q)
            2'd0:    byte_c = dmem_rdata_in[7:0];
            2'd1:    byte_c = dmem_rdata_in[15:8];
            2'd2:    byte_c = dmem_rdata_in[23:16];
            default: byte_c = dmem_rdata_in[31:24];
        endcase
        half_c = addr_lo_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (f3_q)
            F3_B:    load_data_c = {{24{byte_c[7]}}, byte_c};
            F3_H:    load_data_c = {{16{half_c[15]}}, half_c};
            F3_BU:   load_data_c = {24'd0, byte_c};
            F3_HU:   load_data_c = {16'd0, half_c};
            default: load_data_c = dmem_rdata_in;
        endcase
    end

    // Load completes on rvalid in WAIT, or on rvalid coincident with the grant
    assign load_done_c = ((state == S_REQ) & dmem_gnt_in & is_load_q & dmem_rvalid_in)
                       | ((state == S_WAIT) & dmem_rvalid_in);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; completion takes priority over the watchdog
    always_comb begin
        state_nxt = state;
        abort_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_in & legal_mem_c) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_gnt_in) begin
                    if (!is_load_q || dmem_rvalid_in) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else if (timeout_c) begin
                    state_nxt = S_IDLE;
                    abort_c   = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_in) begin
                    state_nxt = S_IDLE;
                end else if (timeout_c) begin
                    state_nxt = S_IDLE;
                    abort_c   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered bus request, captured access context and write-back outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_data_out    <= '0;
            rd_valid_out   <= 1'b0;
            access_err_out <= 1'b0;
            dmem_req_out   <= 1'b0;
            dmem_we_out    <= 1'b0;
            dmem_addr_out  <= '0;
            dmem_be_out    <= '0;
            dmem_wdata_out <= '0;
            addr_lo_q      <= 2'd0;
            f3_q           <= 3'd0;
            is_load_q      <= 1'b0;
        end else begin
            rd_valid_out   <= 1'b0;
            access_err_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (!is_mem_c) begin
                            rd_data_out  <= alu_res_in;
                            rd_valid_out <= 1'b1;
                        end else if (!legal_mem_c) begin
                            access_err_out <= 1'b1;
                        end else begin
                            dmem_req_out   <= 1'b1;
                            dmem_we_out    <= ~mem_read_in;
                            dmem_addr_out  <= {alu_res_in[WIDTH-1:2], 2'b00};
                            dmem_be_out    <= be_c;
                            dmem_wdata_out <= wdata_c;
                            addr_lo_q      <= alu_res_in[1:0];
                            f3_q           <= funct3_in;
                            is_load_q      <= mem_read_in;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_in | abort_c) begin
                        dmem_req_out <= 1'b0;
                        dmem_we_out  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (load_done_c) begin
                rd_data_out  <= load_data_c;
                rd_valid_out <= 1'b1;
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] wd_cnt;

    // Watchdog counts cycles spent in the current REQ/WAIT visit
    always_ff @(posedge clk_in) begin
        if (rst_in || state == S_IDLE || state_nxt != state) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign timeout_c = (state != S_IDLE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // One-cycle bus error pulse when the watchdog aborts an access
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus_err_out <= 1'b0;
        end else begin
            bus_err_out <= abort_c;
        end
    end
`else
    assign timeout_c   = 1'b0;
    assign bus_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed cases followed by randomized
// traffic against a behavioural memory model and a reference decoder.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        valid_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        branch_in = 1'b0;
    logic [2:0]  funct3_in = 3'd0;
    logic        zero_in = 1'b0;
    logic [31:0] alu_res_in = 32'd0;
    logic [31:0] rs2_in = 32'd0;
    logic [31:0] pc_branch_in = 32'd0;
    logic        pc_src_out;
    logic [31:0] pc_branch_out;
    logic        stall_out;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [3:0]  dmem_be_out;
    logic [31:0] dmem_wdata_out;
    logic        dmem_gnt_in = 1'b0;
    logic        dmem_rvalid_in = 1'b0;
    logic [31:0] dmem_rdata_in = 32'd0;
    logic [31:0] rd_data_out;
    logic        rd_valid_out;
    logic        access_err_out;
    logic        bus_err_out;

    always #5 clk = ~clk;

    mem_access #(.WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_in(branch_in), .funct3_in(funct3_in), .zero_in(zero_in),
        .alu_res_in(alu_res_in), .rs2_in(rs2_in), .pc_branch_in(pc_branch_in),
        .pc_src_out(pc_src_out), .pc_branch_out(pc_branch_out), .stall_out(stall_out),
        .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out), .dmem_be_out(dmem_be_out),
        .dmem_wdata_out(dmem_wdata_out), .dmem_gnt_in(dmem_gnt_in),
        .dmem_rvalid_in(dmem_rvalid_in), .dmem_rdata_in(dmem_rdata_in),
        .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
        .access_err_out(access_err_out), .bus_err_out(bus_err_out)
    );

    typedef struct { bit is_err; logic [31:0] data; } resp_t;
    typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;

    resp_t exp_resp[$];
    bus_t  exp_bus[$];
    int    total = 0;
    int    bad = 0;
    bit    auto_mem = 1'b0;
    int    pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;
    bus_t  rb;
    resp_t rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'hA5A5_1234;
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned nbytes;
        if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b0;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        return (addr % nbytes) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned b;
        int unsigned h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    // Issue one EX result; waits for the stage to be free, records expectations
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rword, output logic st);
        int guard;
        int unsigned nbytes;
        bus_t  b;
        resp_t r;
        guard = 0;
        valid_in = 1'b0;
        #1;
        while (stall_out && guard < 500) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL issue_wait: stall_out=%b expected 0 within 500 cycles", stall_out);
        end
        mem_read_in  = rd;
        mem_write_in = wr;
        funct3_in    = f3;
        alu_res_in   = addr;
        rs2_in       = data;
        branch_in    = 1'b0;
        valid_in     = 1'b1;
        #1;
        st = stall_out;
        if (!(rd || wr)) begin
            r.is_err = 1'b0;
            r.data   = addr;
            exp_resp.push_back(r);
        end else if (!ref_legal(f3, addr)) begin
            r.is_err = 1'b1;
            r.data   = 32'd0;
            exp_resp.push_back(r);
        end else begin
            nbytes  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            b.we    = !rd;
            b.addr  = addr & ~32'h3;
            b.be    = 4'(((1 << nbytes) - 1) << (addr % 4));
            b.wdata = (nbytes == 1) ? (data & 32'hFF) * 32'h0101_0101 :
                      (nbytes == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
            exp_bus.push_back(b);
            if (rd) begin
                r.is_err = 1'b0;
                r.data   = ref_load(f3, addr, rword);
                exp_resp.push_back(r);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Memory responder: random grant delay, random read latency, stray rvalids
    always @(negedge clk) begin
        if (auto_mem) begin
            dmem_gnt_in    = 1'b0;
            dmem_rvalid_in = 1'b0;
            dmem_rdata_in  = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    dmem_rvalid_in = 1'b1;
                    dmem_rdata_in  = mem_word(pend_addr);
                end
            end else if (dmem_req_out && $urandom_range(0, 2) != 0) begin
                dmem_gnt_in = 1'b1;
                if (exp_bus.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: req at addr %h, expected no request", dmem_addr_out);
                end else begin
                    rb = exp_bus.pop_front();
                    check("bus_we", 32'(dmem_we_out), 32'(rb.we));
                    check("bus_addr", dmem_addr_out, rb.addr);
                    if (rb.we) begin
                        check("bus_be", 32'(dmem_be_out), 32'(rb.be));
                        check("bus_wdata", dmem_wdata_out, rb.wdata);
                    end
                end
                if (!dmem_we_out) begin
                    if ($urandom_range(0, 2) == 0) begin
                        dmem_rvalid_in = 1'b1;
                        dmem_rdata_in  = mem_word(dmem_addr_out);
                    end else begin
                        pend_cnt  = $urandom_range(1, 3);
                        pend_addr = dmem_addr_out;
                    end
                end
            end else if ($urandom_range(0, 7) == 0) begin
                dmem_rvalid_in = 1'b1;
            end
        end
    end

    // Monitor: every write-back or access error must match the next expectation
    always @(negedge clk) begin
        if (rd_valid_out || access_err_out) begin
            if (exp_resp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: rd_valid=%b access_err=%b data=%h, expected none",
                         rd_valid_out, access_err_out, rd_data_out);
            end else begin
                rr = exp_resp.pop_front();
                check("resp_rd_valid", 32'(rd_valid_out), 32'(!rr.is_err));
                check("resp_access_err", 32'(access_err_out), 32'(rr.is_err));
                if (!rr.is_err) check("resp_rd_data", rd_data_out, rr.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        st;
        int          kind;
        int          n;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  legal_f3 [5];
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data_out, 32'd0);
        check("rst_rd_valid", 32'(rd_valid_out), 32'd0);
        check("rst_access_err", 32'(access_err_out), 32'd0);
        check("rst_bus_err", 32'(bus_err_out), 32'd0);
        check("rst_req", 32'(dmem_req_out), 32'd0);
        check("rst_we", 32'(dmem_we_out), 32'd0);
        check("rst_addr", dmem_addr_out, 32'd0);
        check("rst_be", 32'(dmem_be_out), 32'd0);
        check("rst_wdata", dmem_wdata_out, 32'd0);
        rst_in = 1'b0;
        @(negedge clk);

        // ALU pass-through
        issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, st);
        check("alu_stall", 32'(st), 32'd0);
        check("alu_rd_valid", 32'(rd_valid_out), 32'd1);
        check("alu_rd_data", rd_data_out, 32'h0000_1234);

        // LB sign extension with delayed grant and separate rvalid
        issue(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80AB_CDEF, st);
        exp_bus.delete();
        check("lb_stall_accept", 32'(st), 32'd1);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("lb_req", 32'(dmem_req_out), 32'd1);
            check("lb_addr", dmem_addr_out, 32'h0000_0100);
            check("lb_we", 32'(dmem_we_out), 32'd0);
            check("lb_stall_req", 32'(stall_out), 32'd1);
            if (c == 1) dmem_gnt_in = 1'b1;
            @(negedge clk);
        end
        dmem_gnt_in = 1'b0;
        #1;
        check("lb_req_wait", 32'(dmem_req_out), 32'd0);
        check("lb_stall_wait", 32'(stall_out), 32'd1);
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'h80AB_CDEF;
        @(negedge clk);
        dmem_rvalid_in = 1'b0;
        #1;
        check("lb_rd_valid", 32'(rd_valid_out), 32'd1);
        check("lb_rd_data", rd_data_out, 32'hFFFF_FF80);
        check("lb_stall_done", 32'(stall_out), 32'd0);
        @(negedge clk);

        // SH lanes with immediate grant
        issue(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 32'd0, st);
        exp_bus.delete();
        #1;
        check("sh_req", 32'(dmem_req_out), 32'd1);
        check("sh_we", 32'(dmem_we_out), 32'd1);
        check("sh_addr", dmem_addr_out, 32'h0000_0200);
        check("sh_be", 32'(dmem_be_out), 32'b1100);
        check("sh_wdata", dmem_wdata_out, 32'hBEEF_BEEF);
        dmem_gnt_in = 1'b1;
        @(negedge clk);
        dmem_gnt_in = 1'b0;
        #1;
        check("sh_req_drop", 32'(dmem_req_out), 32'd0);
        check("sh_stall", 32'(stall_out), 32'd0);
        @(negedge clk);

        // Misaligned LW and illegal funct3
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'd0, 32'd0, st);
        check("mis_stall", 32'(st), 32'd0);
        check("mis_err", 32'(access_err_out), 32'd1);
        check("mis_req", 32'(dmem_req_out), 32'd0);
        issue(1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'd0, 32'd0, st);
        check("ill_stall", 32'(st), 32'd0);
        check("ill_err", 32'(access_err_out), 32'd1);
        check("ill_req", 32'(dmem_req_out), 32'd0);
        @(negedge clk);

        // Branch resolution (combinational, valid dropped before the edge)
        branch_in = 1'b1; zero_in = 1'b1; pc_branch_in = 32'h40; valid_in = 1'b1;
        #1;
        check("br_taken", 32'(pc_src_out), 32'd1);
        check("br_target", pc_branch_out, 32'h40);
        zero_in = 1'b0;
        #1;
        check("br_not_taken", 32'(pc_src_out), 32'd0);
        zero_in = 1'b1; valid_in = 1'b0;
        #1;
        check("br_invalid", 32'(pc_src_out), 32'd0);
        branch_in = 1'b0; zero_in = 1'b0;
        @(negedge clk);

        // Reset while waiting for read data, then a late rvalid
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'd0, 32'd0, st);
        exp_bus.delete();
        exp_resp.delete();
        dmem_gnt_in = 1'b1;
        @(negedge clk);
        dmem_gnt_in = 1'b0;
        #1;
        check("rstw_stall_wait", 32'(stall_out), 32'd1);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'h1234_5678;
        #1;
        check("rstw_stall", 32'(stall_out), 32'd0);
        check("rstw_req", 32'(dmem_req_out), 32'd0);
        @(negedge clk);
        dmem_rvalid_in = 1'b0;
        check("rstw_no_rd_valid", 32'(rd_valid_out), 32'd0);
        @(negedge clk);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Watchdog abort with a grant that never comes
        issue(1'b0, 1'b1, 3'd2, 32'h0000_0400, 32'h1, 32'd0, st);
        exp_bus.delete();
        n = 0;
        while (!bus_err_out && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("to_bus_err", 32'(bus_err_out), 32'd1);
        check("to_cycles_in_range", 32'(n >= 250 && n <= 260), 32'd1);
        #1;
        check("to_stall", 32'(stall_out), 32'd0);
        check("to_req", 32'(dmem_req_out), 32'd0);
        @(negedge clk);
        check("to_pulse", 32'(bus_err_out), 32'd0);
`endif

        // Randomized traffic against the memory model
        auto_mem = 1'b1;
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            a = $urandom;
            if (kind <= 2) begin
                issue(1'b0, 1'b0, f3, a, $urandom, 32'd0, st);
            end else if (kind <= 6) begin
                issue(1'b1, 1'b0, f3, a, $urandom, mem_word(a & ~32'h3), st);
            end else begin
                issue(1'b0, 1'b1, f3, a, $urandom, 32'd0, st);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        n = 0;
        while ((exp_resp.size() != 0 || exp_bus.size() != 0 || stall_out) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_resp", 32'(exp_resp.size()), 32'd0);
        check("drain_bus", 32'(exp_bus.size()), 32'd0);
        auto_mem = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
